// File: rtl/effects_pkg.sv
// Shared widths, per-sample parameter/tag structs and the saturating shift used
// by both multiply stages of the effects chain.
package effects_pkg;
  localparam int BITS_PER_LEVEL = 12;
  localparam int FXP_SIZE       = 16;
  localparam int GAIN_WIDTH     = 11;
  localparam int GAIN_FRAC      = 4;
  localparam int VOL_WIDTH      = 8;
  localparam int VOL_FRAC       = 7;
  localparam int CNT_WIDTH      = 16;

  localparam int BYP_GAIN = 0;
  localparam int BYP_CLIP = 1;
  localparam int BYP_VOL  = 2;

  // Widest signed x unsigned product (gain path); volume products sign-extend into it.
  localparam int PROD_W = FXP_SIZE + GAIN_WIDTH + 1;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (FXP_SIZE-1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef struct packed {
    logic [GAIN_WIDTH-1:0] gain;
    logic [FXP_SIZE-2:0]   thr;
    logic [VOL_WIDTH-1:0]  vol;
    logic [2:0]            byp;
  } par_t;

  typedef struct packed {
    logic ovf;
    logic clip;
  } tag_t;

  typedef struct packed {
    logic                       ovf;
    logic signed [FXP_SIZE-1:0] val;
  } sat_t;

  function automatic sat_t sat_shift(input logic signed [PROD_W-1:0] p, input int frac);
    logic signed [PROD_W-1:0] s;
    sat_t r;
    s = p >>> frac;
    r.ovf = 1'b0;
    r.val = s[FXP_SIZE-1:0];
    if (s > SAT_MAX) begin
      r.ovf = 1'b1;
      r.val = SAT_MAX[FXP_SIZE-1:0];
    end else if (s < SAT_MIN) begin
      r.ovf = 1'b1;
      r.val = SAT_MIN[FXP_SIZE-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/effects_chain_mul.sv
// Registered signed x unsigned fixed-point multiply, shift and saturate with bypass.
// Holds its output while en is low so idle slots leave the result untouched.
module fxp_mul_sat import effects_pkg::*; #(
  parameter int CW   = GAIN_WIDTH,
  parameter int FRAC = GAIN_FRAC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       byp,
  input  logic signed [FXP_SIZE-1:0] x,
  input  logic [CW-1:0]              coef,
  output logic signed [FXP_SIZE-1:0] y,
  output logic                       ovf
);
  logic signed [FXP_SIZE+CW:0] prod;
  sat_t                        r;

  always_comb begin
    prod = x * $signed({1'b0, coef});
    r    = sat_shift(PROD_W'(prod), FRAC);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      y   <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      y   <= byp ? x : r.val;
      ovf <= byp ? 1'b0 : r.ovf;
    end
  end
endmodule

// File: rtl/effects_chain.sv
// Four-stage streaming effects chain: sign-extend, gain, symmetric clip, volume.
// Parameters ride with each sample; statistics saturate and are updated from S3.
module effects_chain import effects_pkg::*; (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [BITS_PER_LEVEL-1:0] i_sample,
  input  logic [GAIN_WIDTH-1:0]     i_par_gain,
  input  logic [FXP_SIZE-2:0]       i_par_thr,
  input  logic [VOL_WIDTH-1:0]      i_par_vol,
  input  logic [2:0]                i_bypass,
  input  logic                      i_stat_clr,
  output logic                      o_valid,
  output logic [FXP_SIZE-1:0]       o_sample,
  output logic                      o_clip,
  output logic                      o_overflow,
  output logic [CNT_WIDTH-1:0]      o_clip_count
);
  localparam int STAGES = 4;

  logic [STAGES:1]            vld_pipe;
  logic signed [FXP_SIZE-1:0] x0, y1, y2, clip_y, thr_s;
  par_t                       par0;
  logic [FXP_SIZE-2:0]        thr1;
  logic [VOL_WIDTH-1:0]       vol1, vol2;
  logic                       cbyp1, vbyp1, vbyp2, ovf1, ovf3, clip_hit;
  tag_t                       tag2, tag3;
  logic                       ovf_nxt;
  logic [CNT_WIDTH-1:0]       cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      x0       <= '0;
      par0     <= '0;
      thr1     <= '0;
      vol1     <= '0;
      cbyp1    <= 1'b0;
      vbyp1    <= 1'b0;
      y2       <= '0;
      tag2     <= '0;
      vol2     <= '0;
      vbyp2    <= 1'b0;
      tag3     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
      if (i_valid) begin
        x0   <= {{(FXP_SIZE-BITS_PER_LEVEL){i_sample[BITS_PER_LEVEL-1]}}, i_sample};
        par0 <= '{gain: i_par_gain, thr: i_par_thr, vol: i_par_vol, byp: i_bypass};
      end
      if (vld_pipe[1]) begin
        thr1  <= par0.thr;
        vol1  <= par0.vol;
        cbyp1 <= par0.byp[BYP_CLIP];
        vbyp1 <= par0.byp[BYP_VOL];
      end
      if (vld_pipe[2]) begin
        y2    <= clip_y;
        tag2  <= '{ovf: ovf1, clip: clip_hit};
        vol2  <= vol1;
        vbyp2 <= vbyp1;
      end
      if (vld_pipe[3]) tag3 <= tag2;
    end
  end

  fxp_mul_sat #(.CW(GAIN_WIDTH), .FRAC(GAIN_FRAC)) u_gain (
    .clk(clk), .rst(rst), .en(vld_pipe[1]), .byp(par0.byp[BYP_GAIN]),
    .x(x0), .coef(par0.gain), .y(y1), .ovf(ovf1)
  );

  // thr is a magnitude, so both bounds fit in fxp_size bits (-thr >= -(2^15-1)).
  always_comb begin
    thr_s    = $signed({1'b0, thr1});
    clip_y   = y1;
    clip_hit = 1'b0;
    if (!cbyp1) begin
      if (y1 > thr_s) begin
        clip_y   = thr_s;
        clip_hit = 1'b1;
      end else if (y1 < -thr_s) begin
        clip_y   = -thr_s;
        clip_hit = 1'b1;
      end
    end
  end

  fxp_mul_sat #(.CW(VOL_WIDTH), .FRAC(VOL_FRAC)) u_vol (
    .clk(clk), .rst(rst), .en(vld_pipe[3]), .byp(vbyp2),
    .x(y2), .coef(vol2), .y(o_sample), .ovf(ovf3)
  );

  assign o_valid = vld_pipe[STAGES];
  assign o_clip  = tag3.clip & vld_pipe[STAGES];

  // Stats absorb the sample presented on the outputs; a coincident clear acts first.
  always_comb begin
    ovf_nxt = i_stat_clr ? 1'b0 : o_overflow;
    cnt_nxt = i_stat_clr ? '0 : o_clip_count;
    if (vld_pipe[STAGES]) begin
      if (ovf3 | tag3.ovf) ovf_nxt = 1'b1;
      if (tag3.clip && cnt_nxt != '1) cnt_nxt = cnt_nxt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_overflow   <= 1'b0;
      o_clip_count <= '0;
    end else begin
      o_overflow   <= ovf_nxt;
      o_clip_count <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_effects_chain.sv
// Randomised and directed scoreboard bench for effects_chain against an
// arithmetic reference model of gain, clip, volume and the statistics.
module tb_effects_chain;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [11:0] i_sample = '0;
  logic [10:0] i_par_gain = '0;
  logic [14:0] i_par_thr = '0;
  logic [7:0]  i_par_vol = '0;
  logic [2:0]  i_bypass = '0;
  logic        i_stat_clr = 1'b0;
  logic        o_valid;
  logic [15:0] o_sample;
  logic        o_clip;
  logic        o_overflow;
  logic [15:0] o_clip_count;

  effects_chain dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample),
    .i_par_gain(i_par_gain), .i_par_thr(i_par_thr), .i_par_vol(i_par_vol),
    .i_bypass(i_bypass), .i_stat_clr(i_stat_clr), .o_valid(o_valid),
    .o_sample(o_sample), .o_clip(o_clip), .o_overflow(o_overflow),
    .o_clip_count(o_clip_count)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int y; bit clip; bit ovf; } exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   run = 0;
  bit   m_ovf = 0;
  int   m_cnt = 0, m_last = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scale by coef / 2^frac rounding toward -inf, then clamp to 16-bit signed.
  function automatic longint scale(input longint v, input longint c, input int frac, inout bit ovf);
    longint p, d, q;
    p = v * c;
    d = longint'(1) << frac;
    q = (p >= 0) ? p / d : -((-p + d - 1) / d);
    if (q > 32767)  begin q = 32767;  ovf = 1; end
    if (q < -32768) begin q = -32768; ovf = 1; end
    return q;
  endfunction

  function automatic exp_t model(input int x, input int g, input int t, input int vl, input logic [2:0] b);
    exp_t e;
    longint v = x;
    e.ovf = 0; e.clip = 0; e.due = 0;
    if (!b[0]) v = scale(v, g, 4, e.ovf);
    if (!b[1]) begin
      if (v > t)       begin v = t;  e.clip = 1; end
      else if (v < -t) begin v = -t; e.clip = 1; end
    end
    if (!b[2]) v = scale(v, vl, 7, e.ovf);
    e.y = int'(v);
    return e;
  endfunction

  task automatic drive(input bit v, input int x, input int g, input int t, input int vl,
                       input logic [2:0] b, input bit clr);
    exp_t e;
    i_valid = v; i_sample = 12'(x); i_par_gain = 11'(g); i_par_thr = 15'(t);
    i_par_vol = 8'(vl); i_bypass = b; i_stat_clr = clr;
    if (v) begin
      e = model(x, g, t, vl, b);
      e.due = cyc + 4;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 16, 0, 128, 3'b000, 0);
  endtask

  // Monitor: compares outputs every cycle, then advances the stats model for the next edge.
  always @(negedge clk) begin
    exp_t e;
    bit   ev_ovf, ev_clip;
    if (run) begin
      ev_ovf = 0; ev_clip = 0;
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("clip_count", 32'(o_clip_count), m_cnt);
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(o_valid), 0);
          m_last = $signed(o_sample);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("sample", $signed(o_sample), e.y);
          chk("clip", 32'(o_clip), 32'(e.clip));
          m_last = e.y; ev_ovf = e.ovf; ev_clip = e.clip;
        end
      end else begin
        chk("valid_low", 32'(o_valid), 0);
        chk("hold_sample", $signed(o_sample), m_last);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          chk("missing_valid", 0, 1);
          void'(sb.pop_front());
        end
      end
      if (!rst) begin
        sb.delete(); m_ovf = 0; m_cnt = 0; m_last = 0;
      end else begin
        if (i_stat_clr) begin m_ovf = 0; m_cnt = 0; end
        if (ev_ovf) m_ovf = 1;
        if (ev_clip && m_cnt < 65535) m_cnt++;
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    run = 1;
    @(posedge clk); #1;
    rst = 1;
    idle(2);

    // Unity-ish path: x2 gain, clip bypassed, unity volume -> 512
    drive(1, 12'h100, 32, 0, 128, 3'b010, 0);
    idle(6);
    chk("unity_ovf", 32'(o_overflow), 0);
    chk("unity_sample", $signed(o_sample), 512);

    // Symmetric clip at +/-1000
    drive(1, 2047, 256, 1000, 128, 3'b000, 0);
    drive(1, -2048, 256, 1000, 128, 3'b000, 0);
    idle(6);
    chk("clip_count_two", 32'(o_clip_count), 2);
    chk("clip_last_neg", $signed(o_sample), -1000);

    // Gain saturation, then a lone clear
    drive(1, 2047, 11'h3FF, 0, 128, 3'b010, 0);
    idle(6);
    chk("sat_sample", 32'(o_sample), 32'h7FFF);
    chk("sat_ovf", 32'(o_overflow), 1);
    drive(0, 0, 16, 0, 128, 3'b000, 1);
    idle(2);
    chk("clr_ovf", 32'(o_overflow), 0);
    chk("clr_cnt", 32'(o_clip_count), 0);

    // Parameters ride with their own sample
    drive(1, 100, 16, 0, 128, 3'b010, 0);
    drive(1, 100, 48, 0, 128, 3'b010, 0);
    idle(6);
    chk("ride_last", $signed(o_sample), 300);

    // Reset mid-flight drops everything in the pipe
    drive(1, 500, 16, 0, 128, 3'b010, 0);
    drive(1, -500, 16, 0, 128, 3'b010, 0);
    rst = 0;
    drive(1, 7, 16, 0, 128, 3'b010, 0);
    rst = 1;
    idle(6);
    chk("rst_sample", 32'(o_sample), 0);

    // Zero threshold and zero gain/volume corners
    drive(1, 5, 16, 0, 128, 3'b000, 0);
    drive(1, -5, 16, 0, 128, 3'b000, 0);
    drive(1, 0, 16, 0, 128, 3'b000, 0);
    drive(1, 2047, 0, 100, 128, 3'b000, 0);
    drive(1, -2048, 2047, 0, 0, 3'b010, 0);
    idle(6);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      int g, t, vl;
      g  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 2047);
      t  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 32767);
      if ($urandom_range(0, 1) == 1) t = t % 2000;
      vl = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048, g, t, vl,
            3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end
    idle(6);

    // Drive the clip counter to saturation, then clear coincident with a clip
    drive(0, 0, 16, 0, 128, 3'b000, 1);
    for (int n = 0; n < 65540; n++) drive(1, 2047, 16, 10, 128, 3'b000, 0);
    idle(6);
    chk("cnt_saturated", 32'(o_clip_count), 32'hFFFF);
    drive(1, 2047, 16, 10, 128, 3'b000, 0);
    idle(3);
    drive(0, 0, 16, 0, 128, 3'b000, 1);
    idle(2);
    chk("clr_with_clip", 32'(o_clip_count), 1);

    idle(4);
    chk("drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/effects_chain.md
Name: effects_chain

Overview:
- Parametrised successor to the single-overdrive pipeline: a streaming multi-stage effects chain of sign-extend, input gain, symmetric hard clip and output volume.
- Each stage has independent bypass; parameters travel with each sample; statistics are saturating.
- Sits between the ADC sample front-end and the DAC/output formatter; accepts one sample per clock, with bubbles allowed.

Parameters:
- bits_per_level, 12, input sample width (signed two's complement)
- fxp_size, 16, internal/output sample width (signed)
- gain_width, 11, unsigned gain word width
- gain_frac, 4, fractional bits of gain (unity = 1<<gain_frac)
- vol_width, 8, unsigned volume word width
- vol_frac, 7, fractional bits of volume (unity = 1<<vol_frac)
- cnt_width, 16, clip counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- i_valid  in  1  input sample qualifier
- i_sample  in  bits_per_level  signed input sample
- i_par_gain  in  gain_width  gain, unsigned fixed point
- i_par_thr  in  fxp_size-1  clip threshold magnitude, unsigned
- i_par_vol  in  vol_width  volume, unsigned fixed point
- i_bypass  in  3  bit0 gain, bit1 clip, bit2 volume; 1 = pass through
- i_stat_clr  in  1  clears o_overflow and o_clip_count
- o_valid  out  1  output qualifier
- o_sample  out  fxp_size  signed output sample
- o_clip  out  1  clip occurred on this output sample (aligned with o_valid)
- o_overflow  out  1  sticky: saturation occurred in gain or volume
- o_clip_count  out  cnt_width  saturating count of clipped valid samples

Behaviour:
- Reset: rst is synchronous and active-low (rst==0 at a clk edge resets). All pipeline data and valid registers, o_sample, o_valid, o_clip, o_overflow and o_clip_count go to 0. Samples in flight are dropped with no partial output.
- Pipeline: 4 register stages, advancing every clock. No backpressure. Valid bits shift with the data. Latency is exactly 4 clocks from i_valid to o_valid. Throughput is 1 sample per clock.
- S0: sign-extend i_sample to fxp_size. Capture i_par_gain, i_par_thr, i_par_vol and i_bypass into this sample's parameter slot. Parameters ride with the sample, so a parameter change never affects a sample already captured.
- S1 gain: p = x*gain (signed x unsigned), then arithmetic shift right by gain_frac (truncate toward -inf). Saturate to [-2^(fxp_size-1), 2^(fxp_size-1)-1] and set the sample's ovf tag on saturation. If bypassed: output = x and no ovf.
- S2 clip: if y > thr, output thr. If y < -thr, output -thr. In either case set the clip tag. thr=0 forces 0, with the clip tag set for any nonzero y. If bypassed: pass through, and the clip tag is 0.
- S3 volume: same arithmetic as S1 with vol/vol_frac; saturation ORs into the ovf tag. If bypassed: pass through.
- Tags and data on invalid slots do not affect statistics. o_sample holds its last value while o_valid=0.
- Statistics update at S3 output when valid:
  - o_overflow is set by the ovf tag.
  - o_clip_count increments on the clip tag and saturates at all-ones (no wrap).
  - If i_stat_clr and an event occur in the same cycle: clear, then apply the event. The result is count=1 and overflow set when the event has those tags.
  - i_stat_clr alone: count=0, overflow=0.
- Parameter words are unsigned. Gain or volume 0 yields output 0 with no ovf.

Decomposition:
- Package effects_pkg holds:
  - bypass bit index localparams BYP_GAIN=0, BYP_CLIP=1, BYP_VOL=2
  - a typedef struct carrying gain/thr/vol/bypass per sample
  - a tag struct {ovf, clip}
  - a saturating-shift function sat_shift
- One sub-module, fxp_mul_sat: registered signed x unsigned multiply with shift and saturate, plus ovf output and a bypass input. It is instantiated for S1 and S3.

Test Plan:
- Unity path: gain 32 (2.0), clip bypassed, vol 128, i_sample 12'h100 for 1 cycle -> 4 cycles later o_valid=1, o_sample=16'd512, o_clip=0, o_overflow=0.
- Clip: gain 256, thr 1000, vol 128, samples 12'h7FF then 12'h800 -> o_sample 1000 then -1000, o_clip=1 both, o_clip_count=2.
- Saturation: gain 11'h3FF, clip bypassed, sample 12'h7FF -> o_sample 16'h7FFF and o_overflow=1. Then assert i_stat_clr alone -> o_overflow=0, o_clip_count=0.
- Parameter ride-along: back-to-back samples 12'd100 (gain 16) then 12'd100 (gain 48, changed between cycles) -> outputs 100 then 300 on consecutive cycles.
- Reset mid-flight: 3 valid samples issued, rst=0 for 1 cycle at cycle 2 -> no o_valid pulses from those samples, and all outputs 0.
- Counter saturation and simultaneous clear: force the count to all-ones via repeated clips -> it stays 16'hFFFF. Then assert i_stat_clr coincident with a clipped sample -> count=1.
